// File: rtl/silly_function_112_if.sv
// Sample/result bundle for the 3-input truth-table block.
interface silly_function_112_if #(
    parameter int unsigned CNT_W = 32
);
    logic             a;
    logic             b;
    logic             c;
    logic             in_valid;
    logic             y_expected;
    logic             check_en;
    logic             y;
    logic             y_q;
    logic             out_valid;
    logic             err_pulse;
    logic [CNT_W-1:0] eval_count;
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] err_count;

    // Sample source: drives inputs, observes results.
    modport master (
        output a, b, c, in_valid, y_expected, check_en,
        input  y, y_q, out_valid, err_pulse, eval_count, ones_count, err_count
    );

    // Function block: consumes inputs, produces results.
    modport slave (
        input  a, b, c, in_valid, y_expected, check_en,
        output y, y_q, out_valid, err_pulse, eval_count, ones_count, err_count
    );
endinterface

// File: rtl/silly_function_112.sv
// y = (~b & ~c) | (a & ~b), with a registered copy and self-check counters.
module silly_function_112 #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    silly_function_112_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             f_c;
    logic             mismatch_c;
    logic             y_q;
    logic             out_valid_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] eval_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] err_q;

    // Function value and check result for the current sample.
    always_comb begin
        f_c        = (~bus.a & ~bus.b & ~bus.c) | (~bus.b & ~bus.c) | (bus.a & ~bus.b);
        mismatch_c = bus.check_en & (f_c != bus.y_expected);
    end

    // Result registers and saturating counters; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            eval_q      <= '0;
            ones_q      <= '0;
            err_q       <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            err_pulse_q <= bus.in_valid & mismatch_c;
            if (bus.in_valid) begin
                y_q <= f_c;
                if (eval_q != CNT_MAX) eval_q <= eval_q + CNT_ONE;
                if (f_c && ones_q != CNT_MAX) ones_q <= ones_q + CNT_ONE;
                if (mismatch_c && err_q != CNT_MAX) err_q <= err_q + CNT_ONE;
            end
        end
    end

    assign bus.y          = f_c;
    assign bus.y_q        = y_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.eval_count = eval_q;
    assign bus.ones_count = ones_q;
    assign bus.err_count  = err_q;
endmodule

// File: tb/tb_silly_function_112.sv
// Directed bench: a 32-bit-counter instance and a 4-bit-counter instance see the same stimulus.
module tb_silly_function_112;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] tt;

    silly_function_112_if #(.CNT_W(32)) bus32 ();
    silly_function_112_if #(.CNT_W(4))  bus4 ();

    silly_function_112 #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    silly_function_112 #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    assign bus4.a          = bus32.a;
    assign bus4.b          = bus32.b;
    assign bus4.c          = bus32.c;
    assign bus4.in_valid   = bus32.in_valid;
    assign bus4.y_expected = bus32.y_expected;
    assign bus4.check_en   = bus32.check_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    // Drive one cycle at the falling edge, check the combinational y, then advance past the rising edge.
    task automatic apply(input logic [2:0] abc, input logic iv, input logic ye, input logic ce,
                         input logic rst);
        @(negedge clk);
        bus32.a = abc[2];
        bus32.b = abc[1];
        bus32.c = abc[0];
        bus32.in_valid = iv;
        bus32.y_expected = ye;
        bus32.check_en = ce;
        reset = rst;
        #1;
        chk("y_comb", 32'(bus32.y), 32'(tt[abc]));
        chk("y_comb4", 32'(bus4.y), 32'(tt[abc]));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic yq, input logic ov, input logic ep,
                                input int ev, input int on, input int er);
        chk({tag, ".y_q"}, 32'(bus32.y_q), 32'(yq));
        chk({tag, ".out_valid"}, 32'(bus32.out_valid), 32'(ov));
        chk({tag, ".err_pulse"}, 32'(bus32.err_pulse), 32'(ep));
        chk({tag, ".eval"}, bus32.eval_count, 32'(ev));
        chk({tag, ".ones"}, bus32.ones_count, 32'(on));
        chk({tag, ".err"}, bus32.err_count, 32'(er));
        chk({tag, ".y_q4"}, 32'(bus4.y_q), 32'(yq));
        chk({tag, ".out_valid4"}, 32'(bus4.out_valid), 32'(ov));
        chk({tag, ".eval4"}, 32'(bus4.eval_count), sat4(ev));
        chk({tag, ".ones4"}, 32'(bus4.ones_count), sat4(on));
        chk({tag, ".err4"}, 32'(bus4.err_count), sat4(er));
    endtask

    initial begin
        logic [2:0] abc;
        checks = 0;
        errors = 0;
        tt     = 8'b0011_0001;  // bit {a,b,c}: 000,100,101 give 1
        reset  = 1'b0;
        bus32.a = 1'b0; bus32.b = 1'b0; bus32.c = 1'b0;
        bus32.in_valid = 1'b0; bus32.y_expected = 1'b0; bus32.check_en = 1'b0;

        // Reset held with valid samples: nothing registers, y still combinational.
        apply(3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_state("rst0", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply(3'b101, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_state("rst1", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply(3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_state("rst2", 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Full truth-table sweep with correct expectations.
        apply(3'b000, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("sw0", 1'b1, 1'b1, 1'b0, 1, 1, 0);
        apply(3'b001, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("sw1", 1'b0, 1'b1, 1'b0, 2, 1, 0);
        apply(3'b010, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("sw2", 1'b0, 1'b1, 1'b0, 3, 1, 0);
        apply(3'b011, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("sw3", 1'b0, 1'b1, 1'b0, 4, 1, 0);
        apply(3'b100, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("sw4", 1'b1, 1'b1, 1'b0, 5, 2, 0);
        apply(3'b101, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("sw5", 1'b1, 1'b1, 1'b0, 6, 3, 0);
        apply(3'b110, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("sw6", 1'b0, 1'b1, 1'b0, 7, 3, 0);
        apply(3'b111, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("sw7", 1'b0, 1'b1, 1'b0, 8, 3, 0);

        // Deliberate mismatch, then a gap, then the same mismatch with checking off.
        apply(3'b101, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("mis", 1'b1, 1'b1, 1'b1, 9, 4, 1);
        apply(3'b010, 1'b0, 1'b1, 1'b1, 1'b1); expect_state("gap0", 1'b1, 1'b0, 1'b0, 9, 4, 1);
        apply(3'b101, 1'b1, 1'b0, 1'b0, 1'b1); expect_state("nochk", 1'b1, 1'b1, 1'b0, 10, 5, 1);
        apply(3'b000, 1'b0, 1'b0, 1'b1, 1'b1); expect_state("gap1", 1'b1, 1'b0, 1'b0, 10, 5, 1);
        apply(3'b001, 1'b1, 1'b0, 1'b1, 1'b1); expect_state("s001", 1'b0, 1'b1, 1'b0, 11, 5, 1);
        apply(3'b100, 1'b0, 1'b1, 1'b1, 1'b1); expect_state("gap2", 1'b0, 1'b0, 1'b0, 11, 5, 1);

        // Twenty samples of 000: the 4-bit instance saturates at 15.
        for (int i = 0; i < 20; i++) begin
            apply(3'b000, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        expect_state("sat", 1'b1, 1'b1, 1'b0, 31, 25, 1);
        apply(3'b000, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("sat2", 1'b1, 1'b1, 1'b0, 32, 26, 1);

        // Mid-stream reset discards the sample in that cycle; counting restarts.
        apply(3'b011, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("pre", 1'b0, 1'b1, 1'b1, 33, 26, 2);
        apply(3'b100, 1'b1, 1'b1, 1'b1, 1'b0); expect_state("mrst", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply(3'b100, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("post0", 1'b1, 1'b1, 1'b0, 1, 1, 0);
        apply(3'b011, 1'b1, 1'b1, 1'b1, 1'b1); expect_state("post1", 1'b0, 1'b1, 1'b1, 2, 1, 1);
        abc = 3'b110;
        apply(abc, 1'b0, 1'b0, 1'b0, 1'b1); expect_state("post2", 1'b0, 1'b0, 1'b0, 2, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/silly_function_112.md
Name: silly_function_112

Overview:
- Evaluates the 3-input Boolean function y = (~b & ~c) | (a & ~b) on inputs a, b, c.
- Provides a combinational output and a registered, valid-qualified copy of the result.
- Provides built-in self-check logic: compares each registered result against a supplied expected bit and counts evaluations, ones and mismatches.
- Used as a basic combinational building block and as a bring-up/self-test target for the 3-input truth-table flow.

Parameters:
- CNT_W, 32, width of the saturating evaluation, ones and error counters (min 4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low (0 = reset).
- a  input  1  function input a (MSB of index {a,b,c}).
- b  input  1  function input b.
- c  input  1  function input c (LSB).
- in_valid  input  1  a, b, c, y_expected are sampled this cycle.
- y_expected  input  1  expected result for the sampled inputs.
- check_en  input  1  when 1 with in_valid, the sample participates in mismatch checking.
- y  output  1  combinational function result, no clock dependence.
- y_q  output  1  registered result of the last accepted sample.
- out_valid  output  1  y_q/err_pulse valid for one cycle.
- err_pulse  output  1  1 for one cycle when the checked sample mismatched.
- eval_count  output  CNT_W  number of accepted samples.
- ones_count  output  CNT_W  number of accepted samples with result 1.
- err_count  output  CNT_W  number of mismatches.

Behaviour:
- Truth table ({a,b,c} -> y): 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
- y is purely combinational from a, b, c at all times, including during reset.
- All registers update on posedge clk only. reset is sampled synchronously; while reset==0 at an edge, all registers are cleared:
  - y_q=0, out_valid=0, err_pulse=0.
  - eval_count=0, ones_count=0, err_count=0.
- Latency: a sample accepted at edge N (in_valid=1, reset=1) produces out_valid=1 and y_q=f(a,b,c) after edge N (visible from N to N+1).
- out_valid and err_pulse drop to 0 on the next edge unless a new sample is accepted. There is no backpressure; every in_valid cycle is accepted.
- y_q holds its last value when in_valid=0.
- err_pulse=1 after the edge iff in_valid=1, check_en=1 and f(a,b,c) != y_expected. y_expected is ignored when check_en=0.
- Counters at each accepted sample:
  - eval_count += 1.
  - ones_count += 1 if f=1.
  - err_count += 1 on mismatch.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Asserting reset mid-stream discards the in-flight sample: no out_valid is produced for a sample presented in the reset cycle, and counters clear.
- X/Z on inputs is not required to be handled; a bench drives only 0/1.

Test Plan:
- Hold reset=0 for 3 cycles with in_valid=1 -> y_q=0, out_valid=0, all counters 0. y still tracks a,b,c combinationally.
- Sweep {a,b,c}=000..111 with in_valid=1, check_en=1, y_expected from the truth table -> y_q sequence 1,0,0,0,1,1,0,0 one cycle after each input. err_pulse never set; eval_count=8, ones_count=3, err_count=0.
- Drive 101 with y_expected=0, check_en=1 -> y_q=1, err_pulse=1 for one cycle, err_count increments by 1. Repeat with check_en=0 -> no err_pulse, err_count unchanged.
- Insert in_valid=0 gaps between samples -> out_valid=0 in gaps, y_q held, counters unchanged.
- With CNT_W=4, apply 20 samples of 000 -> eval_count and ones_count saturate at 15.
- Assert reset=0 for one cycle mid-sweep -> counters return to 0 after that edge, no out_valid for the reset-cycle sample; counting resumes correctly afterward.
